// File: rtl/sram_arb_pkg.sv
// Shared state encoding, port ids and default widths for the two-port SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int ADDR_W_DEF = 18;
    localparam int DATA_W_DEF = 16;

endpackage

// File: rtl/sram_arb_pick.sv
// Two-way request picker: round-robin on last grant, or strict port-0 priority
// when SRAM_ARB_PRIO0_EN is defined.
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt,
    output logic       o_winner
);

    logic w_winner;

`ifdef SRAM_ARB_PRIO0_EN
    logic w_unused_last;
    assign w_unused_last = i_last;
    assign w_winner      = i_req[0] ? PORT0 : PORT1;
`else
    always_comb begin
        case (i_req)
            2'b01:   w_winner = PORT0;
            2'b10:   w_winner = PORT1;
            2'b11:   w_winner = ~i_last;
            default: w_winner = PORT0;
        endcase
    end
`endif

    assign o_winner = w_winner;
    assign o_gnt    = {(|i_req) & (w_winner == PORT1), (|i_req) & (w_winner == PORT0)};

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-access SRAM controller between two requesters and routes read data
// back to the owning port. Define SRAM_ARB_PRIO0_EN for strict port-0 priority.
// state  | meaning
// S_IDLE | nothing in flight
// S_BUSY | one access in flight, waiting for controller ready
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_p0_req,
    input  logic              i_p0_rw,
    input  logic [ADDR_W-1:0] i_p0_addr,
    input  logic [DATA_W-1:0] i_p0_wdata,
    input  logic              i_p1_req,
    input  logic              i_p1_rw,
    input  logic [ADDR_W-1:0] i_p1_addr,
    input  logic [DATA_W-1:0] i_p1_wdata,
    output logic              o_p0_ack,
    output logic              o_p1_ack,
    output logic              o_p0_rvalid,
    output logic              o_p1_rvalid,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_sram_mem,
    output logic              o_sram_rw,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_wdata,
    input  logic              i_sram_ready,
    input  logic [DATA_W-1:0] i_sram_rdata
);

    state_t            r_state;
    logic              r_owner;
    logic              r_op_rd;
    logic              r_last;
    logic              r_p0_rvalid;
    logic              r_p1_rvalid;
    logic [DATA_W-1:0] r_rdata;

    logic [1:0] w_req;
    logic [1:0] w_gnt;
    logic       w_winner;
    logic       w_complete;
    logic       w_issue;
    logic       w_sel1;

    assign w_req = {i_p1_req, i_p0_req};

    sram_arb_pick u_pick (
        .i_req    (w_req),
        .i_last   (r_last),
        .o_gnt    (w_gnt),
        .o_winner (w_winner)
    );

    assign w_complete = (r_state == S_BUSY) && i_sram_ready;
    assign w_issue    = i_sram_ready && (|w_req) && ((r_state == S_IDLE) || w_complete);

    // Port 0 fields sit on the bus whenever nothing is issued, keeping it quiet.
    assign w_sel1       = w_issue && (w_winner == PORT1);
    assign o_sram_mem   = w_issue;
    assign o_sram_rw    = w_sel1 ? i_p1_rw    : i_p0_rw;
    assign o_sram_addr  = w_sel1 ? i_p1_addr  : i_p0_addr;
    assign o_sram_wdata = w_sel1 ? i_p1_wdata : i_p0_wdata;

    assign o_p0_ack    = w_issue && w_gnt[0];
    assign o_p1_ack    = w_issue && w_gnt[1];
    assign o_p0_rvalid = r_p0_rvalid;
    assign o_p1_rvalid = r_p1_rvalid;
    assign o_rdata     = r_rdata;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_owner     <= PORT0;
            r_op_rd     <= 1'b0;
            r_last      <= PORT1;
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            if (w_complete) begin
                r_state <= S_IDLE;
                if (r_op_rd) begin
                    r_rdata     <= i_sram_rdata;
                    r_p0_rvalid <= (r_owner == PORT0);
                    r_p1_rvalid <= (r_owner == PORT1);
                end
            end
            // A new issue in the completion cycle overrides the return to idle.
            if (w_issue) begin
                r_state <= S_BUSY;
                r_owner <= w_winner;
                r_op_rd <= o_sram_rw;
                r_last  <= w_winner;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: SRAM controller model, spec-level arbitration model,
// and an rvalid monitor fed from an expectation queue.
module tb_sram_arbiter;

    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req   [2];
    logic          rw    [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];

    logic          p0_ack, p1_ack, p0_rvalid, p1_rvalid;
    logic [DW-1:0] rdata;
    logic          o_mem, o_rw;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata;
    logic          sram_ready;
    logic [DW-1:0] sram_rdata;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_p0_req     (req[0]),
        .i_p0_rw      (rw[0]),
        .i_p0_addr    (addr[0]),
        .i_p0_wdata   (wdata[0]),
        .i_p1_req     (req[1]),
        .i_p1_rw      (rw[1]),
        .i_p1_addr    (addr[1]),
        .i_p1_wdata   (wdata[1]),
        .o_p0_ack     (p0_ack),
        .o_p1_ack     (p1_ack),
        .o_p0_rvalid  (p0_rvalid),
        .o_p1_rvalid  (p1_rvalid),
        .o_rdata      (rdata),
        .o_sram_mem   (o_mem),
        .o_sram_rw    (o_rw),
        .o_sram_addr  (o_addr),
        .o_sram_wdata (o_wdata),
        .i_sram_ready (sram_ready),
        .i_sram_rdata (sram_rdata)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] dflt(logic [AW-1:0] a);
        return a[DW-1:0] ^ 16'h5A5A;
    endfunction

    // SRAM controller model: ready when idle, access takes 3 cycles, data valid at ready.
    logic [DW-1:0] ctrl_mem [logic [AW-1:0]];
    int unsigned   c_cnt   = 0;
    logic [DW-1:0] c_rd    = '0;
    logic          c_mem   = 1'b0;
    logic          c_rw    = 1'b0;
    logic [AW-1:0] c_addr  = '0;
    logic [DW-1:0] c_wdata = '0;

    always @(negedge clk) begin
        c_mem   = o_mem;
        c_rw    = o_rw;
        c_addr  = o_addr;
        c_wdata = o_wdata;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            c_cnt <= 2;
        end else if (c_mem) begin
            c_cnt <= 2;
            if (c_rw) c_rd <= ctrl_mem.exists(c_addr) ? ctrl_mem[c_addr] : dflt(c_addr);
            else      ctrl_mem[c_addr] = c_wdata;
        end else if (c_cnt != 0) begin
            c_cnt <= c_cnt - 1;
        end
    end

    assign sram_ready = (c_cnt == 0);
    assign sram_rdata = (c_cnt == 0) ? c_rd : 16'hDEAD;

    // Reference model: who should be granted, what the bus carries, and what read returns when.
    typedef struct { logic port; logic [DW-1:0] data; int due; } exp_t;
    typedef struct { logic port; int cyc; } gnt_t;
    exp_t          q[$];
    gnt_t          glog[$];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic          a_seen [2];
    logic          log_en = 1'b0;
    logic          m_last = 1'b1;
    logic          m_owner = 1'b0;
    logic          m_rd = 1'b0;
    logic [DW-1:0] m_data = '0;
    int            m_done = -1;

    always @(negedge clk) begin
        logic iss, win;
        int   ws;
        a_seen[0] = p0_ack;
        a_seen[1] = p1_ack;
        if (log_en && p0_ack) glog.push_back('{port: 1'b0, cyc: cyc});
        if (log_en && p1_ack) glog.push_back('{port: 1'b1, cyc: cyc});
        if (!rst_n) begin
            m_last = 1'b1;
            m_done = -1;
            while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
        end else begin
            iss = sram_ready && (req[0] || req[1]);
            if (req[0] && !req[1])      win = 1'b0;
            else if (!req[0] && req[1]) win = 1'b1;
`ifdef SRAM_ARB_PRIO0_EN
            else                        win = 1'b0;
`else
            else                        win = !m_last;
`endif
            ws = (iss && win) ? 1 : 0;
            chk("p0_ack", p0_ack, iss && !win);
            chk("p1_ack", p1_ack, iss && win);
            chk("sram_mem", o_mem, iss);
            chk("sram_rw", o_rw, rw[ws]);
            chk("sram_addr", o_addr, addr[ws]);
            chk("sram_wdata", o_wdata, wdata[ws]);
            if (cyc == m_done) begin
                chk("ready_at_done", sram_ready, 1);
                if (m_rd) q.push_back('{port: m_owner, data: m_data, due: cyc + 1});
            end
            if (iss) begin
                m_done  = cyc + 3;
                m_owner = win;
                m_rd    = rw[ws];
                m_last  = win;
                if (rw[ws]) m_data = ref_mem.exists(addr[ws]) ? ref_mem[addr[ws]] : dflt(addr[ws]);
                else        ref_mem[addr[ws]] = wdata[ws];
            end
        end
    end

    // Monitor: every rvalid pops the oldest expectation; overdue expectations are misses.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].due < cyc) begin
            e = q.pop_front();
            n_chk++;
            n_err++;
            $display("FAIL rvalid_missing: no rvalid pulse, expected port %0d data %h at cycle %0d", e.port, e.data, e.due);
        end
        if (p0_rvalid || p1_rvalid) begin
            chk("rvalid_both", p0_rvalid && p1_rvalid, 0);
            if (q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL rvalid_spurious: p0=%0d p1=%0d rdata %h, expected none (cycle %0d)", p0_rvalid, p1_rvalid, rdata, cyc);
            end else begin
                e = q.pop_front();
                chk("rvalid_port", p1_rvalid, e.port);
                chk("rdata", rdata, e.data);
                chk("rvalid_cycle", cyc, e.due);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals();
        chk("rst_mem", o_mem, 0);
        chk("rst_p0_ack", p0_ack, 0);
        chk("rst_p1_ack", p1_ack, 0);
        chk("rst_p0_rvalid", p0_rvalid, 0);
        chk("rst_p1_rvalid", p1_rvalid, 0);
        chk("rst_rdata", rdata, 0);
    endtask

    task automatic apply_reset(int n);
        rst_n  = 1'b0;
        req[0] = 1'b0;
        req[1] = 1'b0;
        repeat (n) tick();
        check_reset_vals();
        rst_n = 1'b1;
    endtask

    task automatic req_one(int p, logic r, logic [AW-1:0] a, logic [DW-1:0] d);
        logic got = 1'b0;
        rw[p]    = r;
        addr[p]  = a;
        wdata[p] = d;
        req[p]   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (a_seen[p]) begin
                got = 1'b1;
                break;
            end
        end
        req[p] = 1'b0;
        chk("ack_wait", got, 1);
    endtask

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(4))
            0:       return 18'h00010;
            1:       return 18'h3FFFF;
            2:       return 18'h00000;
            3:       return 18'h2A5A5;
            default: return 18'($urandom_range(15));
        endcase
    endfunction

    task automatic auto_step(int pr, int pd, bit rd_only);
        tick();
        for (int p = 0; p < 2; p++) begin
            bit wd = 1'b0;
            if (req[p] && a_seen[p]) begin
                req[p] = 1'b0;
            end else if (req[p] && $urandom_range(99) < pd) begin
                req[p] = 1'b0;
                wd     = 1'b1;
            end
            if (!req[p] && !wd && $urandom_range(99) < pr) begin
                rw[p]    = rd_only ? 1'b1 : 1'($urandom_range(1));
                addr[p]  = pick_addr();
                wdata[p] = 16'($urandom);
                req[p]   = 1'b1;
            end
        end
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            req[p]   = 1'b0;
            rw[p]    = 1'b0;
            addr[p]  = '0;
            wdata[p] = '0;
        end
        rst_n = 1'b0;
        ref_mem[18'h00010]  = 16'hBEEF;
        ctrl_mem[18'h00010] = 16'hBEEF;

        apply_reset(3);

        // single read, then p1 write/read at the top address
        req_one(0, 1'b1, 18'h00010, 16'h0000);
        repeat (6) tick();
        req_one(1, 1'b0, 18'h3FFFF, 16'h1234);
        repeat (4) tick();
        req_one(1, 1'b1, 18'h3FFFF, 16'h0000);
        repeat (6) tick();

        // withdrawal: p1 raises during p0's access and drops before completion
        req_one(0, 1'b1, 18'h00020, 16'h0000);
        rw[1]   = 1'b1;
        addr[1] = 18'h00030;
        req[1]  = 1'b1;
        tick();
        req[1]  = 1'b0;
        repeat (6) tick();

        // contention from a fresh reset
        apply_reset(2);
        log_en = 1'b1;
        repeat (16) auto_step(100, 0, 1'b1);
        log_en = 1'b0;
        req[0] = 1'b0;
        req[1] = 1'b0;
        repeat (8) tick();
        chk("grant_count", glog.size() >= 4, 1);
        for (int i = 0; i < 4 && i < glog.size(); i++) begin
`ifdef SRAM_ARB_PRIO0_EN
            chk("grant_port", glog[i].port, 0);
`else
            chk("grant_port", glog[i].port, i % 2);
`endif
            if (i > 0) chk("grant_spacing", glog[i].cyc - glog[i-1].cyc, 3);
        end

        // reset during a read: no rvalid, then a fresh issue
        req_one(0, 1'b1, 18'h00010, 16'h0000);
        tick();
        rst_n = 1'b0;
        tick();
        check_reset_vals();
        rst_n = 1'b1;
        repeat (4) tick();
        req_one(0, 1'b1, 18'h00010, 16'h0000);
        repeat (6) tick();

        repeat (800) auto_step(40, 5, 1'b0);
        req[0] = 1'b0;
        req[1] = 1'b0;
        repeat (10) tick();
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares the single-access SRAM controller between two independent requesters, e.g. the video read path and the general write/read path. It picks one pending request per controller free slot, presents it on the controller's `mem`/`rw`/`addr`/`data_f2s` inputs, and tracks the in-flight access. When a read finishes it returns the read data to the requester that owns that access. It sits directly between the requesters and the SRAM controller, in the same clock domain.

## Interface
- `ADDR_W`, 18, SRAM word address width
- `DATA_W`, 16, SRAM data width

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous reset, active-low
- `p0_req` / `p1_req`  in  1  access request; held until the matching ack
- `p0_rw` / `p1_rw`  in  1  1 = read, 0 = write; stable while req is high
- `p0_addr` / `p1_addr`  in  ADDR_W  word address; stable while req is high
- `p0_wdata` / `p1_wdata`  in  DATA_W  write data; stable while req is high
- `p0_ack` / `p1_ack`  out  1  one-cycle pulse: request accepted and issued
- `p0_rvalid` / `p1_rvalid`  out  1  one-cycle pulse: `rdata` valid for this port
- `rdata`  out  DATA_W  registered read data, shared by both ports
- `sram_mem`  out  1  controller `mem`
- `sram_rw`  out  1  controller `rw`
- `sram_addr`  out  ADDR_W  controller `addr`
- `sram_wdata`  out  DATA_W  controller `data_f2s`
- `sram_ready`  in  1  controller `ready`
- `sram_rdata`  in  DATA_W  controller `data_s2f_r`

## Operation
- FSM states: `S_IDLE` (nothing in flight) and `S_BUSY` (one access in flight). Registers: `owner` (port id), `op_rd`, and `last` (last granted port).
- Issue condition, evaluated every cycle: `sram_ready & (p0_req | p1_req)`, with state `S_IDLE`, or state `S_BUSY` in its completion cycle.
- On issue:
  - Assert `sram_mem`.
  - Mux the winner's rw/addr/wdata onto the `sram_*` outputs.
  - Pulse the winner's ack.
  - Load `owner` and `op_rd`.
  - Set `last` to the winner.
  - Next state is `S_BUSY`.
- Arbitration:
  - One requester: that requester wins.
  - Both requesting: the port that is not `last` wins (round-robin).
  - `last` resets to port 1, so port 0 wins the first contention.
- Completion: the first cycle in `S_BUSY` with `sram_ready`=1.
  - If `op_rd`=1, capture `sram_rdata` into `rdata`, and assert `owner`'s rvalid on the next cycle.
  - Writes produce no rvalid.
  - If the issue condition also holds, issue again in the same cycle (back-to-back). Otherwise go to `S_IDLE`.
- Outside an issue cycle: `sram_mem`=0, and `sram_rw`/`sram_addr`/`sram_wdata` are don't-care. Drive them from port 0 to keep them stable.
- A requester may drop req before its ack; the request is then withdrawn with no side effects.

## Timing
- Reset values:
  - `sram_mem`=0, `p0_ack`=`p1_ack`=0, `p0_rvalid`=`p1_rvalid`=0.
  - `rdata`=0, state `S_IDLE`, `last`=1, `owner`=0, `op_rd`=0.
- `sram_mem`, the `sram_*` muxed outputs and both acks are combinational from the registered state, `sram_ready` and the port inputs.
- Read, issued at cycle t:
  - Controller is in rd1 at t+1 and rd2 at t+2, both with ready=0.
  - Completion at t+3 (ready=1); `rvalid` and `rdata` at t+4.
- Write, issued at cycle t: completion at t+3; the next issue is possible at t+3.
- Sustained throughput is one access per 3 cycles, alternating between ports under contention.
- Reset asserted mid-access: the arbiter returns to `S_IDLE` and pending rvalid is lost. The system resets the controller in the same cycle.
- `sram_ready`=0 while in `S_IDLE` (controller not yet idle after reset): no issue, no ack.

## Configuration
- `SRAM_ARB_PRIO0_EN` defined: strict priority. Port 0 wins every contention and `last` is ignored. Port 1 may starve, which is acceptable for video fetch.
- `SRAM_ARB_PRIO0_EN` undefined: round-robin as described above.

## Structure
- Package `sram_arb_pkg`:
  - FSM state encoding (`S_IDLE`, `S_BUSY`).
  - Port id constants `PORT0`=1'b0 and `PORT1`=1'b1.
  - Default `ADDR_W`/`DATA_W`.
- Sub-module `sram_arb_pick`: combinational 2-way picker. Inputs: `req[1:0]`, `last`. Outputs: `gnt[1:0]`, `winner`. The `SRAM_ARB_PRIO0_EN` selection lives here.

## Test plan
- Single read: p0 reads addr 0x00010 while the controller model returns 0xBEEF. Expect `p0_ack` at t, `sram_mem`=1 with `sram_rw`=1 at t, `p0_rvalid` at t+4 with `rdata`=0xBEEF, and no `p1_rvalid`.
- Write then read:
  - p1 writes 0x1234 to 0x3FFFF: `sram_wdata`=0x1234 and `sram_addr`=0x3FFFF at the issue cycle, with no rvalid.
  - p1 then reads 0x3FFFF: `p1_rvalid` with 0x1234.
- Contention: p0 and p1 request reads continuously. Without the macro, grants go p0, p1, p0, p1 at 3-cycle spacing. With `SRAM_ARB_PRIO0_EN`, only p0 is granted.
- Back-to-back: p1 is pending when p0's read completes. `p1_ack` is in the same cycle as p0's completion, and `p0_rvalid` comes one cycle later.
- Withdrawal: p1 raises req while p0 is in flight, then drops it before completion. Expect no `p1_ack` and `sram_mem`=0 at completion.
- Reset mid-read: `reset`=0 at t+2 of a p0 read. Expect all outputs at reset values, no `p0_rvalid`, and a fresh issue after release.
